// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with a small trap/mret sequencer.
// The CSRs are mstatus, mie, mip, mtvec, mepc, mcause, mtval and mscratch,
// plus the 64-bit mcycle and minstret counters split into 32-bit halves.
// Trap flow: IDLE -> SAVE (CSR update) -> REDIRECT (one-cycle redirect).
// Define CSR_VECTORED_EN to enable vectored interrupt dispatch when mtvec[1:0]=01.
module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RST_MTVEC   = 32'h000002C4,
  parameter logic [XLEN-1:0] RST_MSTATUS = 32'h00000088
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            instr_retire,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [2:0]      irq_i,
  input  logic            mret_i,
  output logic            trap_busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            global_int_en
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  // Only MIE (bit 3) and MPIE (bit 7) exist in mstatus.
  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(32'h88);
  localparam logic [XLEN-1:0] EPC_MASK     = ~XLEN'(3);
`ifdef CSR_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_MASK   = '1;
`else
  localparam logic [XLEN-1:0] MTVEC_MASK   = ~XLEN'(3);
`endif

  typedef enum logic [1:0] {IDLE, SAVE, REDIRECT} state_e;

  // Trap context captured on acceptance so later input changes cannot disturb it.
  typedef struct packed {
    logic            is_irq;
    logic            is_mret;
    logic [3:0]      cause;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tval;
  } trap_t;

  state_e          state_q, state_d;
  trap_t           trap_q, trap_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [XLEN-1:0] mip;
  logic            int_take;
  logic [3:0]      int_cause;
  logic [XLEN-1:0] wr_masked;
  logic            wr_ok;
  logic [XLEN-1:0] rd_stored;
  logic [XLEN-1:0] trap_target;

  assign mip = XLEN'({irq_i[2], 3'b000, irq_i[1], 3'b000, irq_i[0], 3'b000});

  // Pending-interrupt detection and fixed priority MEI > MSI > MTI.
  always_comb begin
    int_take  = mstatus_q[3] & ((mie_q[11] & irq_i[2]) | (mie_q[3] & irq_i[0]) |
                                (mie_q[7] & irq_i[1]));
    int_cause = 4'd7;
    if (mie_q[11] & irq_i[2])     int_cause = 4'd11;
    else if (mie_q[3] & irq_i[0]) int_cause = 4'd3;
  end

  // Next-state logic; requests are only looked at in IDLE, so busy ignores them.
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          state_d = SAVE;
          trap_d  = '{is_irq: 1'b0, is_mret: 1'b0, cause: exc_cause,
                      pc: trap_pc, tval: exc_tval};
        end else if (int_take) begin
          state_d = SAVE;
          trap_d  = '{is_irq: 1'b1, is_mret: 1'b0, cause: int_cause,
                      pc: trap_pc, tval: '0};
        end else if (mret_i) begin
          state_d        = REDIRECT;
          trap_d.is_irq  = 1'b0;
          trap_d.is_mret = 1'b1;
        end
      end
      SAVE:     state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Legal-value view of the software write, also used for read bypass.
  always_comb begin
    wr_masked = wr_data;
    wr_ok     = 1'b1;
    case (wr_addr)
      A_MSTATUS:                          wr_masked = wr_data & MSTATUS_MASK;
      A_MTVEC:                            wr_masked = wr_data & MTVEC_MASK;
      A_MEPC:                             wr_masked = wr_data & EPC_MASK;
      A_MIE, A_MSCRATCH, A_MCAUSE, A_MTVAL,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: wr_masked = wr_data;
      default: begin
        wr_masked = '0;
        wr_ok     = 1'b0;
      end
    endcase
  end

  // CSR next values: software write first, then trap/mret updates override it.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mscratch_d = mscratch_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instr_retire};
    if (wr_en) begin
      case (wr_addr)
        A_MSTATUS:   mstatus_d  = wr_masked;
        A_MIE:       mie_d      = wr_masked;
        A_MTVEC:     mtvec_d    = wr_masked;
        A_MEPC:      mepc_d     = wr_masked;
        A_MCAUSE:    mcause_d   = wr_masked;
        A_MTVAL:     mtval_d    = wr_masked;
        A_MSCRATCH:  mscratch_d = wr_masked;
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wr_data[31:0]};
        A_MCYCLEH:   mcycle_d   = {wr_data[31:0], mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wr_data[31:0]};
        A_MINSTRETH: minstret_d = {wr_data[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
    if (state_q == SAVE) begin
      mepc_d             = trap_q.pc & EPC_MASK;
      mcause_d           = '0;
      mcause_d[XLEN-1]   = trap_q.is_irq;
      mcause_d[3:0]      = trap_q.cause;
      mtval_d            = trap_q.is_irq ? '0 : trap_q.tval;
      mstatus_d          = '0;
      mstatus_d[7]       = mstatus_q[3];
    end
    if (state_q == REDIRECT && trap_q.is_mret) begin
      mstatus_d    = '0;
      mstatus_d[3] = mstatus_q[7];
      mstatus_d[7] = 1'b1;
    end
  end

  // State and CSR registers; reset aborts any in-flight trap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      trap_q     <= '0;
      mstatus_q  <= RST_MSTATUS & MSTATUS_MASK;
      mie_q      <= '0;
      mtvec_q    <= RST_MTVEC & MTVEC_MASK;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      trap_q     <= trap_d;
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Combinational read port with same-cycle write bypass.
  always_comb begin
    rd_stored = '0;
    case (rd_addr)
      A_MSTATUS:   rd_stored = mstatus_q;
      A_MIE:       rd_stored = mie_q;
      A_MIP:       rd_stored = mip;
      A_MTVEC:     rd_stored = mtvec_q;
      A_MEPC:      rd_stored = mepc_q;
      A_MCAUSE:    rd_stored = mcause_q;
      A_MTVAL:     rd_stored = mtval_q;
      A_MSCRATCH:  rd_stored = mscratch_q;
      A_MCYCLE:    rd_stored = XLEN'(mcycle_q[31:0]);
      A_MCYCLEH:   rd_stored = XLEN'(mcycle_q[63:32]);
      A_MINSTRET:  rd_stored = XLEN'(minstret_q[31:0]);
      A_MINSTRETH: rd_stored = XLEN'(minstret_q[63:32]);
      default:     rd_stored = '0;
    endcase
    rd_data = rd_stored;
    if (wr_en && wr_ok && (wr_addr == rd_addr)) rd_data = wr_masked;
  end

  // Redirect target: mepc for mret, mtvec base (optionally vectored) for traps.
  always_comb begin
    trap_target = mtvec_q & ~XLEN'(3);
`ifdef CSR_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01 && trap_q.is_irq)
      trap_target = (mtvec_q & ~XLEN'(3)) + XLEN'({trap_q.cause, 2'b00});
`endif
  end

  assign trap_busy      = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = !redirect_valid ? '0 :
                          (trap_q.is_mret ? mepc_q : trap_target);
  assign global_int_en  = mstatus_q[3];

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: random + directed stimulus against a cycle-scheduled
// behavioural model of the CSR/trap unit; literal checks pin key scenarios.
module tb_csr_trap_unit;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305,
                          A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342,
                          A_MTVAL = 12'h343, A_MIP = 12'h344, A_MCYCLE = 12'hB00,
                          A_MINSTRET = 12'hB02, A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82;
`ifdef CSR_VECTORED_EN
  localparam bit [31:0] TVEC_MASK = 32'hFFFF_FFFF;
`else
  localparam bit [31:0] TVEC_MASK = 32'hFFFF_FFFC;
`endif

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data, trap_pc, exc_tval, redirect_pc;
  logic        wr_en, instr_retire, exc_valid, mret_i, trap_busy, redirect_valid, global_int_en;
  logic [3:0]  exc_cause;
  logic [2:0]  irq_i;

  csr_trap_unit dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .instr_retire(instr_retire),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .trap_pc(trap_pc), .exc_tval(exc_tval),
    .irq_i(irq_i), .mret_i(mret_i), .trap_busy(trap_busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .global_int_en(global_int_en)
  );

  typedef struct {
    bit [11:0] rd_addr, wr_addr;
    bit [31:0] wr_data, trap_pc, exc_tval;
    bit        wr_en, instr_retire, exc_valid, mret_i;
    bit [3:0]  exc_cause;
    bit [2:0]  irq_i;
  } stim_t;
  stim_t st;

  int errors = 0, checks = 0;

  // Model state: architectural CSR values plus the cycle numbers of scheduled events.
  bit        m_mie_b, m_mpie;
  bit [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  bit [63:0] m_cyc, m_ret;
  int        cyc_no, busy_until, save_at, redir_at;
  bit        p_irq, p_mret;
  bit [3:0]  p_cause;
  bit [31:0] p_pc, p_tval;

  localparam bit [11:0] ADDRS [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h123};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mie_b = 1; m_mpie = 1; m_mie = 0; m_mtvec = 32'h2C4 & TVEC_MASK;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_cyc = 0; m_ret = 0;
    cyc_no = 0; busy_until = -1; save_at = -1; redir_at = -1; p_mret = 0; p_irq = 0;
  endtask

  function automatic bit [31:0] model_read(bit [11:0] a, bit [31:0] mip);
    case (a)
      A_MSTATUS:   return {24'd0, m_mpie, 3'd0, m_mie_b, 3'd0};
      A_MIE:       return m_mie;
      A_MIP:       return mip;
      A_MTVEC:     return m_mtvec;
      A_MEPC:      return m_mepc;
      A_MCAUSE:    return m_mcause;
      A_MTVAL:     return m_mtval;
      A_MSCRATCH:  return m_mscratch;
      A_MCYCLE:    return m_cyc[31:0];
      A_MCYCLEH:   return m_cyc[63:32];
      A_MINSTRET:  return m_ret[31:0];
      A_MINSTRETH: return m_ret[63:32];
      default:     return 0;
    endcase
  endfunction

  // What a software write would store (ok=0 for read-only / unimplemented).
  task automatic wr_effect(input bit [11:0] a, input bit [31:0] d, output bit ok, output bit [31:0] v);
    ok = 1; v = d;
    case (a)
      A_MSTATUS: v = d & 32'h88;
      A_MTVEC:   v = d & TVEC_MASK;
      A_MEPC:    v = d & 32'hFFFF_FFFC;
      A_MIE, A_MSCRATCH, A_MCAUSE, A_MTVAL, A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: ;
      default: begin ok = 0; v = 0; end
    endcase
  endtask

  function automatic bit [31:0] model_target();
    bit [31:0] base = m_mtvec & 32'hFFFF_FFFC;
`ifdef CSR_VECTORED_EN
    if (m_mtvec[1:0] == 2'b01 && p_irq) return base + 4 * p_cause;
`endif
    return base;
  endfunction

  // Compare DUT outputs for the current cycle, then advance the model past the next edge.
  task automatic compare_advance();
    bit busy, ok, take_exc, take_irq, take_mret, old_mie, old_mpie;
    bit [31:0] v, mip, pend;
    bit [3:0] icause;
    busy = (cyc_no <= busy_until);
    chk("trap_busy", trap_busy, busy);
    chk("redirect_valid", redirect_valid, cyc_no == redir_at);
    if (cyc_no == redir_at) chk("redirect_pc", redirect_pc, p_mret ? m_mepc : model_target());
    chk("global_int_en", global_int_en, m_mie_b);
    mip = {20'd0, irq_i[2], 3'd0, irq_i[1], 3'd0, irq_i[0], 3'd0};
    wr_effect(wr_addr, wr_data, ok, v);
    chk("rd_data", rd_data, (wr_en && ok && wr_addr == rd_addr) ? v : model_read(rd_addr, mip));
    pend = m_mie & mip & {32{m_mie_b}};
    take_exc  = !busy && exc_valid;
    take_irq  = !busy && !exc_valid && pend != 0;
    take_mret = !busy && !exc_valid && pend == 0 && mret_i;
    icause = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
    old_mie = m_mie_b; old_mpie = m_mpie;
    if (wr_en && ok)
      case (wr_addr)
        A_MSTATUS:  begin m_mie_b = v[3]; m_mpie = v[7]; end
        A_MIE:      m_mie = v;
        A_MTVEC:    m_mtvec = v;
        A_MEPC:     m_mepc = v;
        A_MCAUSE:   m_mcause = v;
        A_MTVAL:    m_mtval = v;
        A_MSCRATCH: m_mscratch = v;
        default: ;
      endcase
    if (wr_en && wr_addr == A_MCYCLE) m_cyc[31:0] = wr_data;
    else if (wr_en && wr_addr == A_MCYCLEH) m_cyc[63:32] = wr_data;
    else m_cyc = m_cyc + 1;
    if (wr_en && wr_addr == A_MINSTRET) m_ret[31:0] = wr_data;
    else if (wr_en && wr_addr == A_MINSTRETH) m_ret[63:32] = wr_data;
    else if (instr_retire) m_ret = m_ret + 1;
    if (cyc_no == save_at) begin
      m_mepc = p_pc & 32'hFFFF_FFFC;
      m_mcause = p_irq ? (32'h8000_0000 | p_cause) : {28'd0, p_cause};
      m_mtval = p_irq ? 0 : p_tval;
      m_mpie = old_mie; m_mie_b = 0;
    end
    if (cyc_no == redir_at && p_mret) begin m_mie_b = old_mpie; m_mpie = 1; end
    if (take_exc || take_irq) begin
      p_irq = take_irq; p_mret = 0; p_cause = take_irq ? icause : exc_cause;
      p_pc = trap_pc; p_tval = exc_tval;
      save_at = cyc_no + 1; redir_at = cyc_no + 2; busy_until = cyc_no + 2;
    end else if (take_mret) begin
      p_mret = 1; p_irq = 0; redir_at = cyc_no + 1; busy_until = cyc_no + 1;
    end
    cyc_no++;
  endtask

  task automatic drive();
    rd_addr = st.rd_addr; wr_addr = st.wr_addr; wr_data = st.wr_data; wr_en = st.wr_en;
    instr_retire = st.instr_retire; exc_valid = st.exc_valid; exc_cause = st.exc_cause;
    trap_pc = st.trap_pc; exc_tval = st.exc_tval; irq_i = st.irq_i; mret_i = st.mret_i;
  endtask

  task automatic idle_st(bit [11:0] ra);
    st = '{rd_addr: ra, wr_addr: 12'h0, wr_data: 0, trap_pc: 0, exc_tval: 0, wr_en: 0,
           instr_retire: 0, exc_valid: 0, mret_i: 0, exc_cause: 0, irq_i: 0};
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1 compare_advance();
  endtask

  task automatic step_rd(bit [11:0] ra);
    idle_st(ra);
    step();
  endtask

  task automatic step_wr(bit [11:0] wa, bit [31:0] wd);
    idle_st(wa); st.wr_en = 1; st.wr_addr = wa; st.wr_data = wd;
    step();
  endtask

  task automatic step_exc(bit [3:0] c, bit [31:0] pc, bit [31:0] tv);
    idle_st(A_MEPC); st.exc_valid = 1; st.exc_cause = c; st.trap_pc = pc; st.exc_tval = tv;
    step();
  endtask

  initial begin
    idle_st(A_MTVEC);
    drive();
    @(negedge clk);
    #1;
    chk("reset trap_busy", trap_busy, 1'b0);
    chk("reset redirect_valid", redirect_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rstn = 1; drive();
    #1 compare_advance();

    // Reset values and free-running cycle counter.
    step_rd(A_MTVEC);   chk("mtvec reset", rd_data, 32'h2C4);
    step_rd(A_MSTATUS); chk("mstatus reset", rd_data, 32'h88);
    step_rd(A_MCYCLE);  chk("mcycle 3", rd_data, 32'd3);
    step_rd(A_MCYCLE);  chk("mcycle 4", rd_data, 32'd4);

    // Exception: redirect two cycles later to mtvec base.
    step_exc(4'd11, 32'h100, 32'h55);
    step_rd(A_MEPC);    chk("exc busy", trap_busy, 1'b1);
    step_rd(A_MEPC);    chk("exc redirect", redirect_valid, 1'b1);
                        chk("exc redirect_pc", redirect_pc, 32'h2C4);
    step_rd(A_MEPC);    chk("exc mepc", rd_data, 32'h100);
    step_rd(A_MCAUSE);  chk("exc mcause", rd_data, 32'd11);
    step_rd(A_MTVAL);   chk("exc mtval", rd_data, 32'h55);
    step_rd(A_MSTATUS); chk("exc mstatus", rd_data, 32'h80);

    // mret: redirect next cycle to mepc, MIE restored.
    idle_st(A_MSTATUS); st.mret_i = 1; step();
    step_rd(A_MSTATUS); chk("mret redirect_pc", redirect_pc, 32'h100);
    step_rd(A_MSTATUS); chk("mret mstatus", rd_data, 32'h88);

    // Interrupt with all lines pending: MEI wins.
`ifdef CSR_VECTORED_EN
    step_wr(A_MTVEC, 32'h201);
`endif
    step_wr(A_MIE, 32'h888);
    idle_st(A_MCAUSE); st.irq_i = 3'b111; st.trap_pc = 32'h444; step();
    step_rd(A_MCAUSE);
    step_rd(A_MCAUSE);
`ifdef CSR_VECTORED_EN
    chk("irq redirect_pc", redirect_pc, 32'h22C);
`else
    chk("irq redirect_pc", redirect_pc, 32'h2C4);
`endif
    step_rd(A_MCAUSE);  chk("irq mcause", rd_data, 32'h8000_000B);
    step_rd(A_MTVAL);   chk("irq mtval", rd_data, 32'h0);
    step_wr(A_MTVEC, 32'h2C4);
    idle_st(A_MSTATUS); st.mret_i = 1; step();
    step_rd(A_MSTATUS);

    // Exception and mret together: trap wins, mret while busy is dropped.
    idle_st(A_MEPC); st.exc_valid = 1; st.exc_cause = 2; st.trap_pc = 32'h200; st.mret_i = 1; step();
    idle_st(A_MEPC); st.mret_i = 1; step();
    step_rd(A_MEPC);    chk("both redirect_pc", redirect_pc, 32'h2C4);
    step_rd(A_MCAUSE);  chk("both no mret", redirect_valid, 1'b0);
                        chk("both mcause", rd_data, 32'd2);

    // Software write during SAVE: mepc write dropped, mscratch write lands.
    step_exc(4'd5, 32'h300, 32'h0);
    step_wr(A_MEPC, 32'h40);
    step_rd(A_MEPC); step_rd(A_MEPC);
    chk("save mepc", rd_data, 32'h300);
    step_exc(4'd6, 32'h304, 32'h0);
    step_wr(A_MSCRATCH, 32'hABCD);
    step_rd(A_MSCRATCH); step_rd(A_MSCRATCH);
    chk("save mscratch", rd_data, 32'hABCD);

    // 64-bit cycle counter wrap.
    step_wr(A_MCYCLEH, 32'hFFFF_FFFF);
    step_wr(A_MCYCLE, 32'hFFFF_FFFF);
    step_rd(A_MCYCLEH); chk("mcycle all-ones", rd_data, 32'hFFFF_FFFF);
    step_rd(A_MCYCLEH); chk("mcycle wrap hi", rd_data, 32'h0);
    step_rd(A_MCYCLE);  chk("mcycle wrap lo", rd_data, 32'h1);

    // Reset asserted while in SAVE aborts the trap.
    step_exc(4'd7, 32'h500, 32'h9);
    step_rd(A_MEPC);
    #1 rstn = 0;
    #1;
    chk("mid-reset busy", trap_busy, 1'b0);
    chk("mid-reset redirect", redirect_valid, 1'b0);
    model_reset();
    idle_st(A_MEPC);
    @(negedge clk);
    rstn = 1; drive();
    #1 compare_advance();
    chk("mid-reset mepc", rd_data, 32'h0);
    step_rd(A_MEPC); chk("mid-reset no redirect", redirect_valid, 1'b0);
    step_rd(A_MEPC);

    // Random traffic checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      st.rd_addr      = ADDRS[$urandom_range(0, 12)];
      st.wr_addr      = ADDRS[$urandom_range(0, 12)];
      st.wr_en        = ($urandom_range(0, 9) < 3);
      st.wr_data      = $urandom;
      st.instr_retire = $urandom_range(0, 1);
      st.exc_valid    = ($urandom_range(0, 99) < 8);
      st.exc_cause    = 4'($urandom);
      st.trap_pc      = $urandom;
      st.exc_tval     = $urandom;
      st.mret_i       = ($urandom_range(0, 99) < 8);
      st.irq_i        = ($urandom_range(0, 9) < 3) ? 3'($urandom) : 3'd0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width of the CSRs and PCs.
REQ-002 SHALL have parameter RST_MTVEC, default 32'h000002C4, meaning the mtvec reset value.
REQ-003 SHALL have parameter RST_MSTATUS, default 32'h00000088, meaning the mstatus reset value.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are listed below with clock and reset first.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 rd_addr  input  12  CSR read address.
REQ-008 rd_data  output  XLEN  CSR read data (combinational).
REQ-009 wr_en / wr_addr / wr_data  input  1/12/XLEN  software CSR write.
REQ-010 instr_retire  input  1  one instruction retired this cycle.
REQ-011 exc_valid / exc_cause  input  1/4  synchronous exception request and its code.
REQ-012 trap_pc / exc_tval  input  XLEN/XLEN  PC to save in mepc and the faulting value.
REQ-013 irq_i  input  3  {meip, mtip, msip} level interrupt lines.
REQ-014 mret_i  input  1  mret request.
REQ-015 trap_busy  output  1  high while the FSM is in SAVE or REDIRECT.
REQ-016 redirect_valid / redirect_pc  output  1/XLEN  one-cycle pipeline redirect and its target.
REQ-017 global_int_en  output  1  equals mstatus[3].

Function
REQ-018 SHALL implement mstatus (bits 3 MIE and 7 MPIE writable, all other bits 0), mie, mip (read-only, bits 3/7/11 = msip/mtip/meip), mtvec, mepc (bits [1:0] read 0), mcause, mtval, mscratch, mcycle/mcycleh and minstret/minstreth; unimplemented addresses SHALL read 0 and ignore writes.
REQ-019 rd_data SHALL return wr_data (after the REQ-018 masking) when wr_en=1 and wr_addr==rd_addr, and the stored value otherwise.
REQ-020 mcycle SHALL be 64-bit and increment every cycle; minstret SHALL be 64-bit and increment when instr_retire=1; a software write to either half SHALL replace that half and suppress the increment in that cycle; the counters wrap from all-ones to 0.
REQ-021 The FSM SHALL have states IDLE, SAVE and REDIRECT.
REQ-022 In IDLE, priority SHALL be exc_valid, then a pending interrupt (mstatus.MIE & (mie & mip) != 0), then mret_i; exc_valid or an interrupt moves the FSM to SAVE, and mret_i moves it to REDIRECT.
REQ-023 Interrupt priority SHALL be MEI(11) > MSI(3) > MTI(7); mcause[XLEN-1]=1 for an interrupt and 0 for an exception.
REQ-024 On the SAVE->REDIRECT edge, the unit SHALL set mepc=trap_pc, mcause, mtval=exc_tval (0 for an interrupt), MPIE=MIE and MIE=0, with trap_pc and exc_tval sampled on entry to SAVE.
REQ-025 In REDIRECT, redirect_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; for a trap the target is the mtvec base, and for mret the target is mepc, with MIE=MPIE and MPIE=1.
REQ-026 Latency: an exception or interrupt in cycle N SHALL give redirect_valid in cycle N+2; mret in cycle N SHALL give redirect_valid in cycle N+1.
REQ-027 exc_valid, mret_i and interrupts SHALL be ignored while trap_busy=1.
REQ-028 An FSM update SHALL take priority over wr_en to the same CSR in the same cycle, and the software write SHALL be dropped; writes to other CSRs in that cycle still occur.

Reset
REQ-029 On rstn low, the FSM SHALL go to IDLE; mtvec=RST_MTVEC, mstatus=RST_MSTATUS, all other CSRs and counters 0, redirect_valid=0, trap_busy=0; reset mid-trap SHALL abort the trap without updating any CSR.

Configuration
REQ-030 The macro CSR_VECTORED_EN SHALL select the trap vectoring mode.
REQ-031 With CSR_VECTORED_EN defined: mtvec[1:0] SHALL be writable; when mtvec[1:0]=01, an interrupt target SHALL be {mtvec[XLEN-1:2],2'b00}+4*cause, while exceptions always use the base.
REQ-032 Without CSR_VECTORED_EN: mtvec[1:0] SHALL read 0 and all traps SHALL use the base.

Verification
REQ-033 Reset, then read mtvec/mstatus -> 0x2C4/0x88; mcycle counts up by 1 per cycle.
REQ-034 exc_valid, cause=11, trap_pc=0x100 at cycle N -> redirect_valid at N+2 with pc 0x2C4; mepc=0x100, mcause=11, mstatus=0x80.
REQ-035 mie=0x888, MIE=1, irq_i=3'b111 -> mcause=0x8000000B; with CSR_VECTORED_EN and mtvec=0x201, the target is 0x22C.
REQ-036 Same-cycle exc_valid and mret_i -> the trap is taken; mret is ignored and is not accepted while busy.
REQ-037 wr_en to mepc=0x40 during SAVE -> mepc holds trap_pc; a write to mscratch in the same cycle lands.
REQ-038 mcycle=0xFFFFFFFF_FFFFFFFF -> next value 0; rstn pulsed in SAVE -> no mepc update and redirect_valid stays 0.
